// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared definitions for the AES-128 round-key schedule sequencer.
// Holds the scheduler select encodings, the AES-128 round count and the
// sequencer state encodings.
package aes_key_sched_ctrl_pkg;

    localparam int unsigned AES128_NR = 10;

    // Key scheduler register select
    localparam logic [1:0] KS_HOLD = 2'b00;
    localparam logic [1:0] KS_LOAD = 2'b01;
    localparam logic [1:0] KS_FWD  = 2'b10;
    localparam logic [1:0] KS_REV  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_EXPAND  = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the 128-bit round-key scheduler. Drives the scheduler
// select/round so that round keys appear in ascending (encrypt) or
// descending (decrypt) order, each offered through a valid/ready handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, decrypt    begin a sequence (sampled in IDLE) and its direction
//   ks_ctrl, ks_round scheduler select and round number (combinational)
//   rk_valid, rk_index, rk_ready  round-key handshake toward the datapath
//   busy, done        activity flag and one-cycle completion pulse
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int unsigned NR = AES128_NR,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          decrypt,
    output logic [1:0]    ks_ctrl,
    output logic [RW-1:0] ks_round,
    output logic          rk_valid,
    output logic [RW-1:0] rk_index,
    input  logic          rk_ready,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] idx_q, idx_d;
    logic          last_key_c;

    // Final key of the sequence is index NR ascending, index 0 descending
    assign last_key_c = dir_q ? (idx_q == '0) : (idx_q == RW'(NR));
    assign rk_index   = idx_q;

    // Next-state and scheduler control
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ks_ctrl  = KS_HOLD;
        ks_round = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d   = decrypt;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ks_ctrl = KS_LOAD;
                cnt_d   = RW'(1);
                if (dir_q) begin
                    state_d = ST_EXPAND;
                end else begin
                    idx_d   = '0;
                    state_d = ST_PRESENT;
                end
            end
            // Decrypt walks the scheduler forward to key NR before presenting
            ST_EXPAND: begin
                ks_ctrl  = KS_FWD;
                ks_round = cnt_q;
                if (cnt_q == RW'(NR)) begin
                    idx_d   = RW'(NR);
                    state_d = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            // Step the scheduler on the consuming edge so keys flow without bubbles
            ST_PRESENT: begin
                if (rk_ready) begin
                    if (last_key_c) begin
                        state_d = ST_DONE;
                    end else if (dir_q) begin
                        ks_ctrl  = KS_REV;
                        ks_round = idx_q;
                        idx_d    = idx_q - RW'(1);
                    end else begin
                        ks_ctrl  = KS_FWD;
                        ks_round = idx_q + RW'(1);
                        idx_d    = idx_q + RW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            cnt_q    <= RW'(1);
            idx_q    <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rk_valid <= (state_d == ST_PRESENT);
            busy     <= (state_d != ST_IDLE);
            done     <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl. A behavioural AES-128 key
// scheduler register follows ks_ctrl/ks_round so the presented key values
// can be checked against the FIPS-197 expansion of 000102..0f.
module tb_aes_key_sched_ctrl;
    import aes_key_sched_ctrl_pkg::*;

    localparam int unsigned NR = 10;
    localparam int unsigned RW = 4;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        bit dec;
        int stall;
        bit poke;
        bit hold;
        int first;
        int dn;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          decrypt = 1'b0;
    logic          rk_ready = 1'b0;
    logic [1:0]    ks_ctrl;
    logic [RW-1:0] ks_round;
    logic          rk_valid;
    logic [RW-1:0] rk_index;
    logic          busy;
    logic          done;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0]   sbox [256];
    logic [127:0] exp_key [NR+1];
    logic [127:0] sched_key;
    vec_t         vecs [6];

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .decrypt  (decrypt),
        .ks_ctrl  (ks_ctrl),
        .ks_round (ks_round),
        .rk_valid (rk_valid),
        .rk_index (rk_index),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 1; i < r; i++) c = xt(c);
        return c;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox[r[31:24]], sbox[r[23:16]], sbox[r[15:8]], sbox[r[7:0]]};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input int r);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(r), 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_rev(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rcon(r), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // Key scheduler register model
    always @(posedge clk) begin
        case (ks_ctrl)
            KS_LOAD: sched_key <= FIPS_KEY;
            KS_FWD:  sched_key <= key_fwd(sched_key, int'(ks_round));
            KS_REV:  sched_key <= key_rev(sched_key, int'(ks_round));
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, want);
    endtask

    // Starts a sequence from an IDLE cycle and follows it to the IDLE cycle after done
    task automatic run_seq(input vec_t v, input string tag);
        int cyc;
        int exp_idx;
        int stall_cnt;
        int nkeys;
        bit got_first;
        bit fin;
        bit poked;
        bit last;
        cyc = 0; stall_cnt = 0; nkeys = 0; got_first = 0; fin = 0; poked = 0;
        exp_idx = v.dec ? int'(NR) : 0;
        start = 1'b1; decrypt = v.dec; rk_ready = 1'b0;
        #1;
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle ks_ctrl"}, ks_ctrl, KS_HOLD);
        while (!fin && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start = v.hold; decrypt = v.dec;
            if (rk_valid) begin
                rk_ready = (stall_cnt >= v.stall);
                if (v.poke && !poked && rk_index == RW'(5)) begin
                    start = 1'b1; decrypt = 1'b1; poked = 1;
                end
            end else begin
                rk_ready = 1'b1;
            end
            #1;
            if (cyc == 1) begin
                check({tag, " load ks_ctrl"}, ks_ctrl, KS_LOAD);
                check({tag, " load ks_round"}, ks_round, 0);
                check({tag, " load busy"}, busy, 1);
                check({tag, " load rk_valid"}, rk_valid, 0);
            end else if (done) begin
                check({tag, " done cycle"}, cyc, v.dn);
                check({tag, " keys consumed"}, nkeys, NR + 1);
                check({tag, " done ks_ctrl"}, ks_ctrl, KS_HOLD);
                check({tag, " done busy"}, busy, 1);
                check({tag, " done rk_valid"}, rk_valid, 0);
                fin = 1;
            end else if (rk_valid) begin
                if (!got_first) begin
                    check({tag, " first valid cycle"}, cyc, v.first);
                    got_first = 1;
                end
                check($sformatf("%s index #%0d", tag, nkeys), rk_index, exp_idx);
                check($sformatf("%s key %0d", tag, exp_idx), sched_key, exp_key[exp_idx]);
                if (exp_idx == int'(NR)) check({tag, " key 10 fips"}, sched_key, FIPS_K10);
                if (exp_idx == 0) check({tag, " key 0 fips"}, sched_key, FIPS_KEY);
                if (rk_ready) begin
                    last = v.dec ? (exp_idx == 0) : (exp_idx == int'(NR));
                    if (last) begin
                        check({tag, " last ks_ctrl"}, ks_ctrl, KS_HOLD);
                        check({tag, " last ks_round"}, ks_round, 0);
                    end else if (v.dec) begin
                        check($sformatf("%s rev ks_ctrl %0d", tag, exp_idx), ks_ctrl, KS_REV);
                        check($sformatf("%s rev ks_round %0d", tag, exp_idx), ks_round, exp_idx);
                        exp_idx--;
                    end else begin
                        check($sformatf("%s fwd ks_ctrl %0d", tag, exp_idx), ks_ctrl, KS_FWD);
                        check($sformatf("%s fwd ks_round %0d", tag, exp_idx), ks_round, exp_idx + 1);
                        exp_idx++;
                    end
                    nkeys++;
                    stall_cnt = 0;
                end else begin
                    check($sformatf("%s stall ks_ctrl %0d", tag, exp_idx), ks_ctrl, KS_HOLD);
                    check($sformatf("%s stall ks_round %0d", tag, exp_idx), ks_round, 0);
                    stall_cnt++;
                end
            end else if (v.dec && cyc <= int'(NR) + 1) begin
                check($sformatf("%s expand ks_ctrl c%0d", tag, cyc), ks_ctrl, KS_FWD);
                check($sformatf("%s expand ks_round c%0d", tag, cyc), ks_round, cyc - 1);
            end else begin
                check($sformatf("%s gap ks_ctrl c%0d", tag, cyc), ks_ctrl, KS_HOLD);
            end
        end
        if (!fin) check({tag, " timeout waiting for done"}, 0, 1);
        @(posedge clk); #1;
        start = v.hold; decrypt = v.dec; rk_ready = 1'b0;
        #1;
        check({tag, " after done busy"}, busy, 0);
        check({tag, " after done pulse"}, done, 0);
        check({tag, " after done rk_valid"}, rk_valid, 0);
    endtask

    initial begin
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] r;
        bit found;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv; r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox[a] = s ^ 8'h63;
        end
        exp_key[0] = FIPS_KEY;
        for (int i = 1; i <= int'(NR); i++) exp_key[i] = key_fwd(exp_key[i-1], i);

        //          dec  stall poke hold first done
        vecs[0] = '{1'b0, 0, 1'b0, 1'b0, 2,  13};
        vecs[1] = '{1'b1, 0, 1'b0, 1'b0, 12, 23};
        vecs[2] = '{1'b0, 3, 1'b0, 1'b0, 2,  46};
        vecs[3] = '{1'b1, 3, 1'b0, 1'b0, 12, 56};
        vecs[4] = '{1'b0, 0, 1'b1, 1'b0, 2,  13};
        vecs[5] = '{1'b0, 1, 1'b0, 1'b0, 2,  24};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset ks_ctrl", ks_ctrl, KS_HOLD);
        check("reset ks_round", ks_round, 0);
        check("reset rk_valid", rk_valid, 0);
        check("reset rk_index", rk_index, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_seq(vecs[i], $sformatf("vec%0d", i));

        // Reset during EXPAND at counter 6 (previous run left rk_index at NR)
        start = 1'b1; decrypt = 1'b1; rk_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (ks_ctrl == KS_FWD && ks_round == RW'(6) && !rk_valid) found = 1;
        end
        check("reach expand counter 6", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid rst ks_ctrl", ks_ctrl, KS_HOLD);
        check("mid rst ks_round", ks_round, 0);
        check("mid rst rk_valid", rk_valid, 0);
        check("mid rst rk_index", rk_index, 0);
        check("mid rst busy", busy, 0);
        check("mid rst done", done, 0);
        run_seq('{1'b1, 0, 1'b0, 1'b0, 12, 23}, "post-reset desc");

        // start held high: next LOAD two cycles after done
        run_seq('{1'b0, 0, 1'b0, 1'b1, 2, 13}, "b2b run1");
        run_seq('{1'b1, 0, 1'b0, 1'b1, 12, 23}, "b2b run2");
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final idle busy", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
